// File: rtl/sig_driver.sv
// Line driver: holds each accepted level for HOLD cycles and can emit one
// deliberate inverted pulse of 1..3 cycles, restoring the prior level after.
module sig_driver #(
  parameter int HOLD = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       glitch_req,
  input  logic [1:0] glitch_len,
  output logic       sig_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_GLITCH = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sig_q, sig_d;
  logic       saved_q, saved_d;

  assign ready_out = (state_q == ST_IDLE);
  assign busy      = ~ready_out;
  assign sig_out   = sig_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    saved_d = saved_q;
    case (state_q)
      ST_IDLE: begin
        // A level request wins; a coincident glitch request is dropped.
        if (valid_in) begin
          sig_d   = data_in;
          cnt_d   = HOLD_LAST;
          state_d = ST_HOLD;
        end else if (glitch_req) begin
          saved_d = sig_q;
          sig_d   = ~sig_q;
          cnt_d   = (glitch_len == 2'd0) ? 4'd0 : {2'b00, glitch_len - 2'd1};
          state_d = ST_GLITCH;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GLITCH: begin
        if (cnt_q == 4'd0) begin
          sig_d   = saved_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sig_q   <= 1'b0;
      saved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      saved_q <= saved_d;
    end
  end

endmodule

// File: tb/tb_sig_driver.sv
// Scoreboard bench for sig_driver: a waveform-queue model predicts the line
// and busy status per cycle; a monitor pops and compares after every edge.
module tb_sig_driver;
  localparam int H = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       glitch_req = 1'b0;
  logic [1:0] glitch_len = 2'd0;
  logic       sig_out;
  logic       busy;

  sig_driver #(.HOLD(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .glitch_req (glitch_req),
    .glitch_len (glitch_len),
    .sig_out    (sig_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic sig;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: upcoming busy-cycle line levels, and the level the line rests at.
  logic sched[$];
  logic rest      = 1'b0;
  logic busy_prev = 1'b0;

  // 3-sample agreement filter applied to the DUT line.
  logic [2:0] filt_s = 3'b000;
  logic       filt_out = 1'b0;
  int         filt_changes = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic v, input logic d,
                       input logic g, input logic [1:0] gl);
    exp_t e;
    int   len;
    @(negedge clock);
    reset = rst_n; valid_in = v; data_in = d; glitch_req = g; glitch_len = gl;
    if (!rst_n) begin
      sched.delete();
      rest = 1'b0;
      e.sig = 1'b0;
      e.busy = 1'b0;
    end else begin
      if (!busy_prev && v) begin
        for (int i = 0; i < H; i++) sched.push_back(d);
        rest = d;
      end else if (!busy_prev && g) begin
        len = (gl == 2'd0) ? 1 : int'(gl);
        for (int i = 0; i < len; i++) sched.push_back(~rest);
      end
      if (sched.size() > 0) begin
        e.sig = sched.pop_front();
        e.busy = 1'b1;
      end else begin
        e.sig = rest;
        e.busy = 1'b0;
      end
    end
    busy_prev = e.busy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic filter_test(input logic [1:0] gl, input int want);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(H + 4);
    filt_changes = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, gl);
    idle(8);
    @(posedge clock); #2;
    check($sformatf("filter_toggles_len%0d", gl), filt_changes, want);
  endtask

  // Monitor: compare after every edge, then advance the filter.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sig_out", int'(sig_out), int'(e.sig));
        check("ready_out", int'(ready_out), int'(!e.busy));
        check("busy", int'(busy), int'(e.busy));
        $display("cycle t=%0t sig=%b ready=%b busy=%b", $time, sig_out, ready_out, busy);
      end
      if (!reset) begin
        filt_s = 3'b000;
        filt_out = 1'b0;
      end else begin
        filt_s = {filt_s[1:0], sig_out};
        if ((filt_s == 3'b111 || filt_s == 3'b000) && filt_out != filt_s[0]) begin
          filt_out = filt_s[0];
          filt_changes++;
        end
      end
    end
  end

  initial begin
    // Reset, then basic hold of a 1 level.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(H + 3);
    // Glitch widths 2, 0 (one cycle), 3, with glitch_len changed mid-glitch.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    idle(3);
    // Simultaneous level and glitch requests: level wins.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
    idle(H + 2);
    // Requests while busy, data toggling every cycle.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < H + 3; i++) cycle(1'b1, 1'b1, logic'(i % 2), 1'b1, 2'd1);
    idle(H + 1);
    // Reset in the third HOLD cycle of a 1 level.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
    idle(4);
    // Glitches seen through the 3-sample filter.
    filter_test(2'd1, 0);
    filter_test(2'd2, 0);
    filter_test(2'd3, 2);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cycle(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)));
    end
    @(posedge clock); #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
